// File: rtl/shift_feed_if.sv
// Parallel-in handshake and serial-out bundle for shift_feed.
// slave = serializer side, master = producer/observer side.
interface shift_feed_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]           din;
    logic                       din_valid;
    logic                       din_ready;
    logic                       data;
    logic                       bit_valid;
    logic                       word_start;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    modport slave (
        input  din, din_valid,
        output din_ready, data, bit_valid, word_start, busy, fifo_count
    );

    modport master (
        output din, din_valid,
        input  din_ready, data, bit_valid, word_start, busy, fifo_count
    );
endinterface

// File: rtl/shift_feed.sv
// FIFO-fed parallel-to-serial feeder producing a gapless bit stream
// with frame markers for a downstream every-cycle shifter.
module shift_feed #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input logic         clk,
    input logic         clr,
    shift_feed_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sr, w_sr_nx, w_head;
    logic [NW-1:0]    r_cnt, w_cnt_nx;
    logic             r_data, w_data_nx;
    logic             r_bv, w_bv_nx;
    logic             r_ws, w_ws_nx;
    logic             w_push, w_pop, w_load;

    function automatic logic f_first(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0) return v[0];
        else                return v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0) return v >> 1;
        else                return v << 1;
    endfunction

    assign w_head        = r_mem[r_rptr];
    assign bus.din_ready = (r_count < CW'(DEPTH));
    assign w_push        = bus.din_valid && bus.din_ready;

    always_comb begin
        w_state_nx = r_state;
        w_sr_nx    = r_sr;
        w_cnt_nx   = r_cnt;
        w_data_nx  = IDLE_BIT;
        w_bv_nx    = 1'b0;
        w_ws_nx    = 1'b0;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        unique case (r_state)
            S_IDLE: w_load = (r_count != '0);
            S_SHIFT: begin
                if (r_cnt < NW'(WIDTH)) begin
                    w_data_nx = f_first(r_sr);
                    w_sr_nx   = f_shift(r_sr);
                    w_cnt_nx  = r_cnt + NW'(1);
                    w_bv_nx   = 1'b1;
                end else if (r_count != '0) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
        endcase
        // Loading emits the first bit on the same edge, so there is no gap.
        if (w_load) begin
            w_pop      = 1'b1;
            w_data_nx  = f_first(w_head);
            w_sr_nx    = f_shift(w_head);
            w_cnt_nx   = NW'(1);
            w_bv_nx    = 1'b1;
            w_ws_nx    = 1'b1;
            w_state_nx = S_SHIFT;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_data  <= IDLE_BIT;
            r_bv    <= 1'b0;
            r_ws    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sr    <= w_sr_nx;
            r_cnt   <= w_cnt_nx;
            r_data  <= w_data_nx;
            r_bv    <= w_bv_nx;
            r_ws    <= w_ws_nx;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.din;
    end

    assign bus.data       = r_data;
    assign bus.bit_valid  = r_bv;
    assign bus.word_start = r_ws;
    assign bus.busy       = (r_state == S_SHIFT);
    assign bus.fifo_count = r_count;
endmodule

// File: doc/shift_feed.md
# shift_feed

Upstream serializer for the 8-bit `shift` capture register. Accepts parallel words over a valid/ready handshake into a small FIFO and drives them out one bit per clock on `data`. The serial stream is back-to-back with no gaps while words are queued, so the downstream shifter, which shifts every cycle, sees contiguous frames. `bit_valid` and `word_start` mark frame boundaries for downstream word alignment.

## Interface
- `WIDTH`, default 8: bits per word.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit `WIDTH-1` first.
- `IDLE_BIT`, default 0: level driven on `data` when no bit is being sent.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `clr`, input, 1: asynchronous, active-high reset.
- `din`, input, WIDTH: parallel word to enqueue.
- `din_valid`, input, 1: `din` is valid this cycle.
- `din_ready`, output, 1: FIFO can accept a word.
- `data`, output, 1: serial bit, registered; feeds the downstream `data` input.
- `bit_valid`, output, 1: `data` carries a payload bit this cycle, registered.
- `word_start`, output, 1: `data` is the first bit of a word, registered.
- `busy`, output, 1: serializer is in SHIFT.
- `fifo_count`, output, clog2(DEPTH+1): number of queued words.

## Operation
- **Reset (`clr`=1, asynchronous):** FIFO emptied, pointers cleared, state IDLE.
  - Outputs: `data`=IDLE_BIT, `bit_valid`=0, `word_start`=0, `busy`=0, `fifo_count`=0, `din_ready`=1.
  - A frame in flight is abandoned and never resumed.
- **FIFO:**
  - Push when `din_valid && din_ready`.
  - `din_ready` = (`fifo_count` < DEPTH), combinational from count only. It does not look ahead to a same-cycle pop, so a full FIFO refuses a push even while popping.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- **State machine, two states (IDLE, SHIFT):**
  - IDLE: if `fifo_count` > 0, pop the head word, load the shift register, emit the first bit (`bit_valid`=1, `word_start`=1), set bit counter to 1, go to SHIFT. Otherwise hold `data`=IDLE_BIT, `bit_valid`=0.
  - SHIFT, bit counter < WIDTH: emit the next bit, `bit_valid`=1, `word_start`=0, increment counter.
  - SHIFT, bit counter = WIDTH (last bit already emitted):
    - FIFO non-empty: pop and emit the new word's first bit this same edge with `word_start`=1 and counter set to 1. No gap cycle; stay in SHIFT.
    - FIFO empty: `data`=IDLE_BIT, `bit_valid`=0, go to IDLE.
- **Bit order:** LSB_FIRST=1 shifts right and emits bit 0; LSB_FIRST=0 shifts left and emits MSB.
- **Word lifetime:** a popped word is owned by the shift register. FIFO writes never corrupt the word in flight.
- **`busy`:** 1 exactly in SHIFT. Counter width is clog2(WIDTH+1).

## Timing
- **Latency:** word pushed into an empty FIFO while IDLE at edge N. `fifo_count`=1 after N. First bit on `data` with `word_start`=1 after edge N+1. Last bit after edge N+WIDTH.
- **Throughput:** one bit per clock; one word every WIDTH clocks while the FIFO is non-empty.
- **Frame marking:** `word_start` is a 1-cycle pulse, coincident with `bit_valid`.
- **Pop timing:** occurs at the edge that emits a word's first bit; `fifo_count` decrements at that edge.
- **Reset timing:** `clr` deassertion is synchronous-safe; the first load can occur on the second rising edge after deassertion, at the earliest.

## Test plan
- **Reset mid-frame:** push 8'hA5, assert `clr` after 3 bits sent -> outputs immediately `data`=0, `bit_valid`=0, `busy`=0, `fifo_count`=0; no remaining bits appear after release.
- **Single word, LSB first:** push 8'hB4 into empty FIFO at edge N -> `data` sequence 0,0,1,0,1,1,0,1 on cycles N+1..N+8. `word_start` only at N+1; `bit_valid`=0 and `data`=0 at N+9.
- **Back-to-back words:** push 8'hFF then 8'h00 on consecutive cycles -> 8 ones then 8 zeros. `bit_valid` stays 1 for 16 cycles; `word_start` at cycles 1 and 9 only.
- **Full FIFO:** with DEPTH=4, hold `din_valid`=1 with words 1..6 while the first is serialized:
  - `din_ready`=0 once `fifo_count`=4.
  - Refused words are not lost to the bench, which retries them.
  - All six emerge in order.
- **Simultaneous push/pop:** push at the exact edge the next word is popped -> `fifo_count` unchanged, and the pushed word is emitted after the queued ones.
- **MSB first:** LSB_FIRST=0, word 8'hB4 -> `data` sequence 1,0,1,1,0,1,0,0.
